// File: rtl/bp_trace_decoder.sv
// Receive side of the PC-discontinuity trace: turns accepted trace words into
// {pc, delta, first} records behind a 2-entry FIFO, with drop statistics.
module bp_trace_decoder #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 16,
    parameter int ALIGN_CHECK = 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [PC_W-1:0]  trace_data_i,
    input  logic             trace_valid_i,
    output logic             trace_ready_o,
    input  logic             resync_i,
    output logic [PC_W-1:0]  rec_pc_o,
    output logic [PC_W-1:0]  rec_delta_o,
    output logic             rec_first_o,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output logic [CNT_W-1:0] msg_count_o,
    output logic [CNT_W-1:0] dup_count_o,
    output logic             err_misalign_o,
    output logic             dbg_state_o
);

    localparam logic [0:0]       ST_SYNC = 1'b0;
    localparam logic [0:0]       ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Both ports use valid/ready: a transfer happens on the rising edge where
    // valid and ready are both high; the source holds its data until then and
    // ready never depends combinationally on the opposite side's valid/ready.

    logic [0:0]       r_state;
    logic             r_alive;
    logic [PC_W-1:0]  r_prev_pc;
    logic [PC_W-1:0]  r_fifo_pc    [2];
    logic [PC_W-1:0]  r_fifo_delta [2];
    logic             r_fifo_first [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_msg_count;
    logic [CNT_W-1:0] r_dup_count;
    logic             r_err_misalign;

    logic             w_accept;
    logic             w_misalign;
    logic             w_sync_word;
    logic             w_aligned_acc;
    logic             w_push;
    logic             w_dup;
    logic             w_pop;
    logic [PC_W-1:0]  w_delta;

    // r_alive keeps ready low until the first clock after reset release.
    assign trace_ready_o  = r_alive && (r_count < 2'd2);
    assign rec_valid_o    = (r_count != 2'd0);
    assign rec_pc_o       = r_fifo_pc[r_rd_ptr];
    assign rec_delta_o    = r_fifo_delta[r_rd_ptr];
    assign rec_first_o    = r_fifo_first[r_rd_ptr];
    assign msg_count_o    = r_msg_count;
    assign dup_count_o    = r_dup_count;
    assign err_misalign_o = r_err_misalign;
    assign dbg_state_o    = r_state;

    assign w_accept      = trace_valid_i && trace_ready_o;
    assign w_misalign    = (ALIGN_CHECK != 0) && (trace_data_i[1:0] != 2'b00);
    // A resync in the same cycle as an accept makes that word the new anchor.
    assign w_sync_word   = resync_i || (r_state == ST_SYNC);
    assign w_aligned_acc = w_accept && !w_misalign;
    assign w_push        = w_aligned_acc && (w_sync_word || (trace_data_i != r_prev_pc));
    assign w_dup         = w_aligned_acc && !w_sync_word && (trace_data_i == r_prev_pc);
    assign w_pop         = rec_valid_o && rec_ready_i;
    assign w_delta       = w_sync_word ? '0 : (trace_data_i - r_prev_pc);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_SYNC;
            r_prev_pc <= '0;
        end else begin
            if (w_aligned_acc) begin
                r_state <= ST_RUN;
            end else if (resync_i) begin
                r_state <= ST_SYNC;
            end
            if (w_push) begin
                r_prev_pc <= trace_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fifo_pc[0]    <= '0;
            r_fifo_pc[1]    <= '0;
            r_fifo_delta[0] <= '0;
            r_fifo_delta[1] <= '0;
            r_fifo_first[0] <= 1'b0;
            r_fifo_first[1] <= 1'b0;
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= trace_data_i;
            r_fifo_delta[r_wr_ptr] <= w_delta;
            r_fifo_first[r_wr_ptr] <= w_sync_word;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_msg_count    <= '0;
            r_dup_count    <= '0;
            r_err_misalign <= 1'b0;
        end else begin
            if (w_push && (r_msg_count != CNT_MAX)) begin
                r_msg_count <= r_msg_count + 1'b1;
            end
            if (w_dup && (r_dup_count != CNT_MAX)) begin
                r_dup_count <= r_dup_count + 1'b1;
            end
            if (w_accept && w_misalign) begin
                r_err_misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_trace_decoder.sv
// Bench for bp_trace_decoder: constant vector table, directed back-pressure,
// resync and reset corners, then random traffic against a record-level model.
module tb_bp_trace_decoder;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk_i;
    logic             reset_n_i;
    logic [PC_W-1:0]  trace_data_i;
    logic             trace_valid_i;
    logic             trace_ready_o;
    logic             resync_i;
    logic [PC_W-1:0]  rec_pc_o;
    logic [PC_W-1:0]  rec_delta_o;
    logic             rec_first_o;
    logic             rec_valid_o;
    logic             rec_ready_i;
    logic [CNT_W-1:0] msg_count_o;
    logic [CNT_W-1:0] dup_count_o;
    logic             err_misalign_o;
    logic             dbg_state_o;

    bp_trace_decoder #(.PC_W(PC_W), .CNT_W(CNT_W), .ALIGN_CHECK(1)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .trace_data_i(trace_data_i), .trace_valid_i(trace_valid_i),
        .trace_ready_o(trace_ready_o), .resync_i(resync_i),
        .rec_pc_o(rec_pc_o), .rec_delta_o(rec_delta_o), .rec_first_o(rec_first_o),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .msg_count_o(msg_count_o), .dup_count_o(dup_count_o),
        .err_misalign_o(err_misalign_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int total = 0;
    int bad   = 0;

    // expected record = {first, delta, pc}
    logic [2*PC_W:0] exp_q[$];
    logic [2*PC_W:0] mon_exp;

    // record-level reference model
    logic [PC_W-1:0] m_prev;
    bit              m_synced;
    int              m_msg;
    int              m_dup;
    bit              m_err;

    int cons_mode = 0;  // 0: always ready, 1: hold, 2: random

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_prev   = '0;
        m_synced = 0;
        m_msg    = 0;
        m_dup    = 0;
        m_err    = 0;
    endfunction

    function automatic void model_accept(input logic [PC_W-1:0] w, input logic rs,
                                         output bit emit, output logic [2*PC_W:0] rec);
        emit = 0;
        rec  = '0;
        if (rs) m_synced = 0;
        if (w[1:0] != 2'b00) begin
            m_err = 1;
        end else if (!m_synced) begin
            emit = 1;
            rec  = {1'b1, {PC_W{1'b0}}, w};
            m_prev = w;
            m_synced = 1;
            if (m_msg < SAT) m_msg++;
        end else if (w == m_prev) begin
            if (m_dup < SAT) m_dup++;
        end else begin
            emit = 1;
            rec  = {1'b0, PC_W'(w - m_prev), w};
            m_prev = w;
            if (m_msg < SAT) m_msg++;
        end
    endfunction

    task automatic apply_reset();
        reset_n_i = 1'b0;
        trace_valid_i = 1'b0;
        resync_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", 96'(trace_ready_o), 96'd0);
        chk("rst_valid", 96'(rec_valid_o), 96'd0);
        chk("rst_counts", 96'({msg_count_o, dup_count_o, err_misalign_o}), 96'd0);
        chk("rst_rec", 96'({rec_first_o, rec_pc_o, rec_delta_o}), 96'd0);
        chk("rst_state", 96'(dbg_state_o), 96'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [PC_W-1:0] w, input logic rs,
                        output bit emit, output logic [2*PC_W:0] rec);
        int waits = 0;
        emit = 0;
        rec  = '0;
        trace_data_i  = w;
        trace_valid_i = 1'b1;
        resync_i      = rs;
        while (!trace_ready_o && waits < 50) begin
            @(posedge clk_i);
            #1;
            waits++;
        end
        if (!trace_ready_o) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 for word %0h", w);
        end else begin
            model_accept(w, rs, emit, rec);
            @(posedge clk_i);
            #1;
        end
        trace_valid_i = 1'b0;
        resync_i      = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk("drain_empty", 96'(exp_q.size()), 96'd0);
        chk("drain_valid", 96'(rec_valid_o), 96'd0);
    endtask

    task automatic set_cons(input int mode);
        cons_mode = mode;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rec_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (cons_mode)
                0:       rec_ready_i = 1'b1;
                1:       rec_ready_i = 1'b0;
                default: rec_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk_i) begin
        if (reset_n_i && rec_valid_o && rec_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rec_unexpected: got pc=%0h delta=%0h first=%0b expected no record",
                         rec_pc_o, rec_delta_o, rec_first_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rec", 96'({rec_first_o, rec_delta_o, rec_pc_o}), 96'(mon_exp));
            end
        end
    end

    // ---------------- test ----------------
    typedef struct {
        logic [PC_W-1:0] w;
        logic            rs;
        logic            emit;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] delta;
        logic            first;
    } vec_t;

    vec_t tbl[14];

    initial begin : main
        bit              emit;
        logic [2*PC_W:0] rec;
        logic [PC_W-1:0] w;
        logic            rs;
        int              r;

        tbl[0]  = '{32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 1'b1};
        tbl[1]  = '{32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_1000, 1'b0};
        tbl[2]  = '{32'h0000_3000, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_1000, 1'b0};
        tbl[3]  = '{32'h0000_2000, 1'b0, 1'b1, 32'h0000_2000, 32'hFFFF_F000, 1'b0};
        tbl[4]  = '{32'h0000_2000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[5]  = '{32'h0000_1FF0, 1'b0, 1'b1, 32'h0000_1FF0, 32'hFFFF_FFF0, 1'b0};
        tbl[6]  = '{32'h0000_1002, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[7]  = '{32'h0000_1004, 1'b0, 1'b1, 32'h0000_1004, 32'hFFFF_F014, 1'b0};
        tbl[8]  = '{32'h0000_8000, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_0000, 1'b1};
        tbl[9]  = '{32'hFFFF_FFF0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_7FF0, 1'b0};
        tbl[10] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0010, 1'b0};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[12] = '{32'h0000_0007, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        tbl[13] = '{32'h0000_0004, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b0};

        trace_data_i  = '0;
        trace_valid_i = 1'b0;
        resync_i      = 1'b0;
        reset_n_i     = 1'b0;
        apply_reset();

        // table: decode, duplicate, misalign, resync, wraparound delta
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].w, tbl[i].rs, emit, rec);
            if (tbl[i].emit) exp_q.push_back({tbl[i].first, tbl[i].delta, tbl[i].pc});
        end
        drain();
        chk("tbl_msg", 96'(msg_count_o), 96'd10);
        chk("tbl_dup", 96'(dup_count_o), 96'd2);
        chk("tbl_err", 96'(err_misalign_o), 96'd1);

        // back-pressure: two stored, third blocked until the consumer drains
        set_cons(1);
        send(32'h0000_3000, 1'b0, emit, rec);
        exp_q.push_back({1'b0, 32'h0000_2FFC, 32'h0000_3000});
        send(32'h0000_4000, 1'b0, emit, rec);
        exp_q.push_back({1'b0, 32'h0000_1000, 32'h0000_4000});
        chk("full_ready", 96'(trace_ready_o), 96'd0);
        chk("full_valid", 96'(rec_valid_o), 96'd1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("stall_head", 96'({rec_first_o, rec_delta_o, rec_pc_o}),
            96'({1'b0, 32'h0000_2FFC, 32'h0000_3000}));
        chk("stall_ready", 96'(trace_ready_o), 96'd0);
        cons_mode = 0;
        send(32'h0000_5000, 1'b0, emit, rec);
        exp_q.push_back({1'b0, 32'h0000_1000, 32'h0000_5000});
        drain();

        // resync with a queued record: queue intact, new anchor first=1
        set_cons(1);
        send(32'h0000_6000, 1'b0, emit, rec);
        exp_q.push_back({1'b0, 32'h0000_1000, 32'h0000_6000});
        send(32'h0000_8000, 1'b1, emit, rec);
        exp_q.push_back({1'b1, 32'h0000_0000, 32'h0000_8000});
        chk("rs_state", 96'(dbg_state_o), 96'd1);
        cons_mode = 0;
        drain();
        chk("rs_msg", 96'(msg_count_o), 96'd15);

        // resync pulse alone, then an ordinary word is a first record
        resync_i = 1'b1;
        @(posedge clk_i);
        #1;
        resync_i = 1'b0;
        chk("rs_alone_state", 96'(dbg_state_o), 96'd0);
        send(32'h0000_8000, 1'b0, emit, rec);
        exp_q.push_back({1'b1, 32'h0000_0000, 32'h0000_8000});
        drain();

        // reset asserted mid-stream
        set_cons(1);
        send(32'h0000_9000, 1'b0, emit, rec);
        trace_data_i  = 32'h0000_A000;
        trace_valid_i = 1'b1;
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", 96'(rec_valid_o), 96'd0);
        chk("mid_rst_counts", 96'({msg_count_o, dup_count_o, err_misalign_o}), 96'd0);
        chk("mid_rst_ready", 96'(trace_ready_o), 96'd0);
        chk("mid_rst_pc", 96'(rec_pc_o), 96'd0);
        cons_mode = 0;
        apply_reset();

        // saturation of both counters
        for (int k = 1; k <= 20; k++) begin
            send(PC_W'(k * 32'h100), 1'b0, emit, rec);
            if (emit) exp_q.push_back(rec);
        end
        chk("sat_msg", 96'(msg_count_o), 96'(SAT));
        for (int k = 0; k < 20; k++) begin
            send(PC_W'(20 * 32'h100), 1'b0, emit, rec);
            if (emit) exp_q.push_back(rec);
        end
        chk("sat_dup", 96'(dup_count_o), 96'(SAT));
        chk("sat_err", 96'(err_misalign_o), 96'd0);
        drain();

        // random traffic against the model
        apply_reset();
        cons_mode = 2;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2 && m_synced) w = m_prev;
            else if (r == 2) w = ($urandom() & 32'hFFFF_FFFC) | PC_W'($urandom_range(1, 3));
            else if (r == 3) w = m_prev + 32'h4;
            else w = $urandom() & 32'hFFFF_FFFC;
            rs = ($urandom_range(0, 15) == 0);
            send(w, rs, emit, rec);
            if (emit) exp_q.push_back(rec);
            chk("rnd_counts", 96'({msg_count_o, dup_count_o, err_misalign_o}),
                96'({CNT_W'(m_msg), CNT_W'(m_dup), m_err}));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
